// File: rtl/ru_pkg.sv
// ---------------------------------------------------------------------------
// ru_pkg
// Shared definitions for the weight-loading path of the PE array.
//   WGT_W           : weight width in bits (signed two's complement)
//   wgt_t           : signed weight type
//   wgt_ld_state_e  : weight loader FSM states
//   NUM_PE_DEF      : default number of PE weight registers (kernel taps)
//   ADDR_W_DEF      : default weight SRAM address width
// ---------------------------------------------------------------------------
package ru_pkg;

    localparam int WGT_W      = 8;
    localparam int NUM_PE_DEF = 9;
    localparam int ADDR_W_DEF = 10;

    typedef logic signed [WGT_W-1:0] wgt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wgt_ld_state_e;

    // Width needed to index n items (at least one bit).
    function automatic int idx_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

endpackage

// File: rtl/wgt_onehot_dec.sv
// ---------------------------------------------------------------------------
// wgt_onehot_dec
// Maps a delivery index to an N-bit one-hot load strobe.
// Output is all-zero when en is low or the index is out of range.
// Ports:
//   idx    : delivery index (0..N-1)
//   en     : strobe enable
//   onehot : N-bit one-hot strobe, bit idx set when en is high
// ---------------------------------------------------------------------------
module wgt_onehot_dec #(
    parameter int N     = 9,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    // Compare the index against every position; at most one can match.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wgt_loader.sv
// ---------------------------------------------------------------------------
// wgt_loader
// Fetches NUM_PE consecutive weights from the weight SRAM starting at
// base_addr and delivers weight i to PE i through a shared signed weight
// bus plus a one-hot load strobe.
//
// Optional feature macro: WGT_LOADER_BCAST_EN
//   When defined, input bcast is added (sampled with start). bcast=1 issues
//   a single read at base_addr and strobes every PE with that one weight.
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : load request, accepted only in IDLE
//   base_addr  : SRAM address of weight 0, sampled with an accepted start
//   bcast      : (WGT_LOADER_BCAST_EN only) broadcast one weight to all PEs
//   busy       : load in progress (drops in the done cycle)
//   done       : one-cycle pulse after the last strobe
//   mem_ren    : SRAM read enable
//   mem_addr   : SRAM read address (wraps modulo 2^ADDR_W)
//   mem_rdata  : SRAM read data, valid one cycle after mem_ren
//   wgt_out    : signed weight bus to all PE weight registers
//   wgt_load   : one-hot (or all-ones in broadcast) load strobe
//
// Timeline for start sampled at edge E0 (cycle c follows edge E(c-1)):
//   mem_ren cycles 1..NUM_PE, wgt_load[i] cycle i+3, done cycle NUM_PE+3.
// ---------------------------------------------------------------------------
module wgt_loader
    import ru_pkg::*;
#(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
`ifdef WGT_LOADER_BCAST_EN
    input  logic                    bcast,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    mem_ren,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [WGT_W-1:0]        mem_rdata,
    output logic signed [WGT_W-1:0] wgt_out,
    output logic [NUM_PE-1:0]       wgt_load
);

    localparam int CNT_W = $clog2(NUM_PE + 1);
    localparam int IDX_W = idx_width(NUM_PE);
    localparam logic [CNT_W-1:0] NUM_PE_C = CNT_W'(NUM_PE);

    wgt_ld_state_e       state_q,    state_d;
    logic [CNT_W-1:0]    iss_cnt_q,  iss_cnt_d;
    logic [IDX_W-1:0]    dlv_cnt_q,  dlv_cnt_d;
    logic                vld_q,      vld_d;
    logic                mem_ren_q,  mem_ren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    wgt_t                wgt_out_q,  wgt_out_d;
    logic [NUM_PE-1:0]   wgt_load_q, wgt_load_d;
    logic [CNT_W-1:0]    iss_lim_s;
    logic                dec_en_s;
    logic [NUM_PE-1:0]   dec_onehot_s;
`ifdef WGT_LOADER_BCAST_EN
    logic                bcast_q,    bcast_d;
`endif

    // Number of reads to issue and decoder enable; broadcast needs one read
    // and bypasses the per-PE decoder.
`ifdef WGT_LOADER_BCAST_EN
    always_comb begin
        if (bcast_q) begin
            iss_lim_s = CNT_W'(1);
            dec_en_s  = 1'b0;
        end else begin
            iss_lim_s = NUM_PE_C;
            dec_en_s  = vld_q;
        end
    end
`else
    always_comb begin
        iss_lim_s = NUM_PE_C;
        dec_en_s  = vld_q;
    end
`endif

    wgt_onehot_dec #(
        .N     (NUM_PE),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx    (dlv_cnt_q),
        .en     (dec_en_s),
        .onehot (dec_onehot_s)
    );

    // Next-state, read-issue and delivery logic.
    always_comb begin
        state_d    = state_q;
        iss_cnt_d  = iss_cnt_q;
        dlv_cnt_d  = dlv_cnt_q;
        mem_ren_d  = mem_ren_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wgt_out_d  = wgt_out_q;
`ifdef WGT_LOADER_BCAST_EN
        bcast_d    = bcast_q;
`endif
        // The read-data valid bit simply trails the read enable by a cycle.
        vld_d      = mem_ren_q;

        // Delivery: capture returning data and strobe the target PE(s).
        // Data is re-registered so wgt_out and the strobe change together.
        if (vld_q) begin
            wgt_out_d = wgt_t'(mem_rdata);
            dlv_cnt_d = dlv_cnt_q + IDX_W'(1);
        end else begin
            wgt_out_d = wgt_out_q;
        end
`ifdef WGT_LOADER_BCAST_EN
        if (bcast_q) begin
            wgt_load_d = {NUM_PE{vld_q}};
        end else begin
            wgt_load_d = dec_onehot_s;
        end
`else
        wgt_load_d = dec_onehot_s;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    mem_ren_d  = 1'b1;
                    mem_addr_d = base_addr;
                    iss_cnt_d  = CNT_W'(1);
                    dlv_cnt_d  = '0;
                    busy_d     = 1'b1;
`ifdef WGT_LOADER_BCAST_EN
                    bcast_d    = bcast;
`endif
                end else begin
                    mem_ren_d  = 1'b0;
                end
            end
            ISSUE: begin
                // iss_cnt_q counts reads already on the bus.
                if (iss_cnt_q == iss_lim_s) begin
                    mem_ren_d = 1'b0;
                    state_d   = DRAIN;
                end else begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    iss_cnt_d  = iss_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // The last PE's strobe is set in both normal and broadcast
                // mode, so it marks the end of delivery.
                if (wgt_load_q[NUM_PE-1]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_ren_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            iss_cnt_q  <= '0;
            dlv_cnt_q  <= '0;
            vld_q      <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wgt_out_q  <= '0;
            wgt_load_q <= '0;
`ifdef WGT_LOADER_BCAST_EN
            bcast_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            iss_cnt_q  <= iss_cnt_d;
            dlv_cnt_q  <= dlv_cnt_d;
            vld_q      <= vld_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wgt_out_q  <= wgt_out_d;
            wgt_load_q <= wgt_load_d;
`ifdef WGT_LOADER_BCAST_EN
            bcast_q    <= bcast_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_ren  = mem_ren_q;
    assign mem_addr = mem_addr_q;
    assign wgt_out  = wgt_out_q;
    assign wgt_load = wgt_load_q;

endmodule

// File: doc/wgt_loader.md
Name: wgt_loader

Overview:
Weight-side producer for the PE array's per-PE weight registers. It drives the shared signed 8-bit weight bus and a one-hot load strobe per PE. On a start command it fetches NUM_PE consecutive bytes from the weight SRAM, beginning at base_addr, and delivers byte i to PE i. Sits between the layer controller (start/done) and the weight SRAM / weight register bank.

Parameters:
NUM_PE, 9, number of weight registers served (kernel taps); legal range 1..64
ADDR_W, 10, weight SRAM address width
WGT_W, 8, weight width in bits; signed two's complement

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle load request; sampled only in IDLE
base_addr  input  ADDR_W  SRAM address of weight 0; sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when all NUM_PE strobes have been issued
mem_ren  output  1  SRAM read enable
mem_addr  output  ADDR_W  SRAM read address
mem_rdata  input  WGT_W  SRAM read data; valid exactly one cycle after mem_ren
wgt_out  output  WGT_W  signed weight bus to all PE weight registers
wgt_load  output  NUM_PE  one-hot load strobe; bit i loads PE i from wgt_out

Behaviour:
- Reset is applied by rstn, which is asynchronous and active-low; clock is clk. rstn low clears:
  - state to IDLE
  - busy, done, mem_ren, wgt_load, wgt_out, mem_addr, and all counters to 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0 latches base_addr, clears the issue counter, and goes to ISSUE.
  - start=0 stays in IDLE.
- ISSUE:
  - mem_ren=1 and mem_addr=base+k for k=0..NUM_PE-1, one per cycle, no bubbles.
  - After k=NUM_PE-1 is issued, go to DRAIN.
- Read-data pipeline:
  - A registered valid bit follows mem_ren by one cycle.
  - When the valid bit is high, wgt_out<=mem_rdata and wgt_load<=(1<<j) at the next edge; j is the delivery counter.
  - wgt_load is therefore high two cycles after the corresponding mem_ren. wgt_out is stable and matches for the whole strobe cycle.
- DRAIN: waits until the strobe for PE NUM_PE-1 has been driven, then goes to DONE.
- DONE: done=1 for one cycle, then return to IDLE. busy falls in the same cycle that done pulses.
- Latency (start at E0):
  - mem_ren is high in cycles 1..NUM_PE.
  - wgt_load[i] is high in cycle i+3.
  - done is high in cycle NUM_PE+3.
  - With NUM_PE=9, the whole load takes 12 cycles from start to done.
- wgt_load is all-zero outside delivery cycles, and at most one bit is set. wgt_out holds its last value when no strobe is active.
- Address arithmetic is modulo 2^ADDR_W: base+k wraps past the top address without error.
- start while not IDLE is ignored, with no queuing. base_addr is only sampled with an accepted start.
- rstn asserted mid-load aborts immediately: all outputs go to 0, no done is issued, and already-loaded PEs keep their values.
- NUM_PE=1 is legal: one read, one strobe, done in cycle 4.

Optional Feature:
WGT_LOADER_BCAST_EN:
- Defined: adds input bcast (1 bit), sampled with start.
  - If bcast=1, exactly one SRAM read is issued at base_addr.
  - All wgt_load bits assert together for one cycle, in cycle 3.
  - done pulses in cycle 4.
  - bcast=0 behaves exactly as the default.
- Undefined: the port is absent, and behaviour is as specified above.

Decomposition:
- Shared package ru_pkg holds:
  - WGT_W constant
  - typedef wgt_t (signed logic [WGT_W-1:0])
  - enum wgt_ld_state_e {IDLE, ISSUE, DRAIN, DONE}
  - default NUM_PE
- One sub-module: wgt_onehot_dec, mapping delivery index plus enable to the NUM_PE-bit one-hot strobe; all-zero when the enable is low.

Test Plan:
- Reset, then start with base=0x010 and SRAM[0x010..0x018]=-4..4 -> mem_ren in cycles 1-9, wgt_load[i] in cycle i+3 with wgt_out=i-4, done in cycle 12, each PE register holds its value.
- base=0x3FC with ADDR_W=10 -> mem_addr sequence 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x004; data delivered in order.
- start re-pulsed in cycles 2 and 7 of a load -> ignored; exactly 9 reads and one done; a new start the cycle after done is accepted.
- rstn dropped in cycle 6 -> all outputs 0 asynchronously, no done; after release, a fresh start completes normally in 12 cycles.
- SRAM data 0x80 and 0x7F -> wgt_out carries -128 and +127 unchanged (sign preserved).
- WGT_LOADER_BCAST_EN defined, bcast=1, SRAM[base]=0x35 -> one mem_ren, wgt_load=all-ones in cycle 3 with wgt_out=0x35, done in cycle 4.
